ccd_capture_ctrl: RTL and testbench
===================================

Name: ccd_capture_ctrl

Overview:
Frame-capture sequencer placed between the CCD sensor pins and the Bayer-to-RGB demosaic stage.
- Registers the sensor FVAL/LVAL/data and gates capture on frame boundaries under iSTART/iEND control.
- Produces the qualified pixel stream, the X/Y pixel coordinates whose LSBs select the Bayer phase downstream, and a completed-frame count.
- Guarantees that the demosaic line buffer only ever receives whole, aligned frames.

Parameters:
COLUMN_WIDTH, 1280, active pixels per line; X wraps after COLUMN_WIDTH-1.
ROW_LINES, 1024, active lines per frame; pixels beyond this line count are suppressed.
DATA_W, 10, pixel width.

Ports:
iCLK  in  1  pixel clock; all logic on rising edge.
iRST  in  1  asynchronous, active-low reset.
iSTART  in  1  one-cycle pulse: arm capture.
iEND  in  1  one-cycle pulse: stop capture at the next frame boundary.
iFVAL  in  1  sensor frame valid.
iLVAL  in  1  sensor line valid.
iDATA  in  DATA_W  sensor pixel.
oDATA  out  DATA_W  captured pixel.
oDVAL  out  1  oDATA valid; feeds demosaic iDVAL and line-buffer clken.
oX_Cont  out  11  column of the current oDATA pixel.
oY_Cont  out  11  row of the current oDATA pixel.
oFrame_Cont  out  32  number of completed captured frames.
oBUSY  out  1  high in ARM or CAPTURE.

Behaviour:
Reset:
- State = IDLE.
- All outputs = 0, including the stop-pending flag and the input registers.

Input stage:
- rFVAL, rLVAL and rDATA are registered every cycle.
- Frame start = rFVAL rising edge (previous 0, current 1). Frame end = rFVAL falling edge.

FSM:
- IDLE: oDVAL=0. iSTART -> ARM.
- ARM: oDVAL=0; waits for a frame start, so capture never begins mid-frame. Frame start -> CAPTURE. iEND -> IDLE.
- CAPTURE: iEND sets stop_pending; the frame in progress always completes. On frame end:
  - oFrame_Cont increments (wraps at 2^32).
  - X and Y clear to 0.
  - If stop_pending, go to IDLE and clear stop_pending; otherwise stay in CAPTURE for the next frame.
- iSTART in ARM or CAPTURE: ignored.
- iSTART and iEND in the same cycle: iEND wins. IDLE stays IDLE; ARM goes to IDLE; CAPTURE sets stop_pending.

Pixel qualification:
- A pixel is valid when state = CAPTURE, rFVAL = 1, rLVAL = 1 and Y < ROW_LINES.

Output stage:
- oDATA, oDVAL, oX_Cont and oY_Cont are registered together.
- Latency from iDATA to oDATA is 2 cycles.
- The X/Y values always belong to the pixel on oDATA.
- oDATA holds its last value when oDVAL = 0.

Counters:
- X increments on each valid pixel.
- At X = COLUMN_WIDTH-1, X wraps to 0 and Y increments.
- Y stops at ROW_LINES. Further pixels in that frame are suppressed (oDVAL = 0) until frame end.
- X and Y are not reset by LVAL edges; wrapping is by count only.
- A short line (LVAL drops early) therefore continues its count on the next line. This is intended: it keeps the Bayer phase consistent with the count.

Other:
- oBUSY is combinational from state.
- Async reset mid-frame returns to IDLE. After release, a new iSTART is needed, and capture resumes only at the next frame start.

Decomposition:
- Shared package ccd_pkg holds:
  - the COLUMN_WIDTH/ROW_LINES defaults and DATA_W;
  - the state encoding IDLE=2'd0, ARM=2'd1, CAPTURE=2'd2.
- One sub-module, ccd_xy_counter, holds:
  - X/Y wrap/saturate logic;
  - inputs clear, advance, and the limit parameters;
  - outputs X, Y, and row_full (Y = ROW_LINES).
- The FSM, input registers and output registers stay in ccd_capture_ctrl.

Test Plan:
- Test parameters: COLUMN_WIDTH=4, ROW_LINES=2.
- Reset, then pulse iSTART while FVAL is low; a frame of 2 lines x 4 LVAL pixels, data 1..8 -> oDVAL high for 8 cycles, 2 cycles after the inputs. (X,Y) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1). oFrame_Cont 0->1 on FVAL fall. oBUSY stays 1.
- iSTART asserted mid-frame (FVAL already high) -> no oDVAL for the rest of that frame. Capture starts at the next FVAL rise with X=Y=0.
- Frame of 3 lines x 4 pixels -> only 8 pixels with oDVAL; the third line is suppressed. Next frame starts at (0,0).
- iEND pulsed during line 1 of frame N -> frame N fully output. oFrame_Cont increments once. State is IDLE and oBUSY=0 after FVAL falls. Frame N+1 produces no oDVAL.
- iSTART and iEND in the same cycle from ARM -> IDLE next cycle with oBUSY=0.
- iRST asserted mid-line in CAPTURE -> outputs 0 immediately. After release, no oDVAL until iSTART plus a fresh FVAL rise.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared constants for the CCD capture path: frame geometry defaults, pixel width and FSM encoding.
package ccd_pkg;
  localparam int unsigned COLUMN_WIDTH_DEF = 1280;
  localparam int unsigned ROW_LINES_DEF    = 1024;
  localparam int unsigned DATA_W_DEF       = 10;
  localparam int unsigned XY_W             = 11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
endpackage

// File: rtl/ccd_xy_counter.sv
// Pixel X/Y position counter: X wraps at COLUMN_WIDTH, Y saturates at ROW_LINES.
// Holds the coordinate of the next pixel to be accepted; no backpressure.
module ccd_xy_counter import ccd_pkg::*; #(
  parameter int unsigned COLUMN_WIDTH = COLUMN_WIDTH_DEF,
  parameter int unsigned ROW_LINES    = ROW_LINES_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  input  logic            i_advance,
  output logic [XY_W-1:0] o_x,
  output logic [XY_W-1:0] o_y,
  output logic            o_row_full
);
  localparam logic [XY_W-1:0] LP_X_LAST  = XY_W'(COLUMN_WIDTH - 1);
  localparam logic [XY_W-1:0] LP_Y_LIMIT = XY_W'(ROW_LINES);
  localparam logic [XY_W-1:0] LP_ONE     = XY_W'(1);

  logic [XY_W-1:0] r_x;
  logic [XY_W-1:0] r_y;

  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_row_full = (r_y == LP_Y_LIMIT);

  // Wrapping is by count only, so a short line carries its position into the next line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance && !o_row_full) begin
      if (r_x == LP_X_LAST) begin
        r_x <= '0;
        r_y <= r_y + LP_ONE;
      end else begin
        r_x <= r_x + LP_ONE;
      end
    end
  end
endmodule

// File: rtl/ccd_capture_ctrl.sv
// Frame-aligned CCD capture sequencer feeding demosaic; iDATA->oDATA latency 2 cycles.
// No backpressure: the sensor stream is qualified, never stalled.
module ccd_capture_ctrl import ccd_pkg::*; #(
  parameter int unsigned COLUMN_WIDTH = COLUMN_WIDTH_DEF,
  parameter int unsigned ROW_LINES    = ROW_LINES_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iEND,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [XY_W-1:0]   oX_Cont,
  output logic [XY_W-1:0]   oY_Cont,
  output logic [31:0]       oFrame_Cont,
  output logic              oBUSY
);
  logic              r_fval;
  logic              r_fval_d;
  logic              r_lval;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_state;
  logic              r_stop_pend;
  logic [31:0]       r_frame_cnt;
  logic              r_dval;
  logic [DATA_W-1:0] r_odata;
  logic [XY_W-1:0]   r_ox;
  logic [XY_W-1:0]   r_oy;

  logic              w_frame_start;
  logic              w_frame_end;
  logic              w_capturing;
  logic              w_pix_vld;
  logic              w_frame_done;
  logic              w_row_full;
  logic [XY_W-1:0]   w_x;
  logic [XY_W-1:0]   w_y;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_fval   <= 1'b0;
      r_fval_d <= 1'b0;
      r_lval   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_fval   <= iFVAL;
      r_fval_d <= r_fval;
      r_lval   <= iLVAL;
      r_data   <= iDATA;
    end
  end

  assign w_frame_start = r_fval & ~r_fval_d;
  assign w_frame_end   = ~r_fval & r_fval_d;
  assign w_capturing   = (r_state == ST_CAPTURE);
  assign w_pix_vld     = w_capturing & r_fval & r_lval & ~w_row_full;
  assign w_frame_done  = w_capturing & w_frame_end;

  // iEND takes priority over iSTART; in CAPTURE it only defers the stop to the frame end.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state     <= ST_IDLE;
      r_stop_pend <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iSTART && !iEND) r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (iEND)               r_state <= ST_IDLE;
          else if (w_frame_start) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
            if (r_stop_pend || iEND) begin
              r_state     <= ST_IDLE;
              r_stop_pend <= 1'b0;
            end
          end else if (iEND) begin
            r_stop_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ccd_xy_counter #(
    .COLUMN_WIDTH (COLUMN_WIDTH),
    .ROW_LINES    (ROW_LINES)
  ) u_xy (
    .i_clk      (iCLK),
    .i_rst_n    (iRST),
    .i_clear    (w_frame_done),
    .i_advance  (w_pix_vld),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_row_full (w_row_full)
  );

  // Coordinates are sampled alongside the pixel so they always describe oDATA.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_dval  <= 1'b0;
      r_odata <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else begin
      r_dval <= w_pix_vld;
      if (w_pix_vld) begin
        r_odata <= r_data;
        r_ox    <= w_x;
        r_oy    <= w_y;
      end
    end
  end

  assign oDATA       = r_odata;
  assign oDVAL       = r_dval;
  assign oX_Cont     = r_ox;
  assign oY_Cont     = r_oy;
  assign oFrame_Cont = r_frame_cnt;
  assign oBUSY       = (r_state == ST_ARM) || (r_state == ST_CAPTURE);
endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// Directed bench for ccd_capture_ctrl with a 4x2 frame geometry.
module tb_ccd_capture_ctrl;
  localparam int DW = 10;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iSTART;
  logic          iEND;
  logic          iFVAL;
  logic          iLVAL;
  logic [DW-1:0] iDATA;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [10:0]   oX_Cont;
  logic [10:0]   oY_Cont;
  logic [31:0]   oFrame_Cont;
  logic          oBUSY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cap_d[$];
  int cap_x[$];
  int cap_y[$];
  int cap_c[$];
  int drv_c[$];

  ccd_capture_ctrl #(
    .COLUMN_WIDTH (4),
    .ROW_LINES    (2),
    .DATA_W       (DW)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iDATA       (iDATA),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oBUSY       (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // One clock of sensor input; any pixel the DUT emits is logged with its visible cycle.
  task automatic step(input logic f, input logic l, input int d);
    iFVAL = f;
    iLVAL = l;
    iDATA = DW'(d);
    if (l) drv_c.push_back(cyc);
    @(posedge iCLK);
    #1;
    cyc++;
    if (oDVAL) begin
      cap_d.push_back(int'(oDATA));
      cap_x.push_back(int'(oX_Cont));
      cap_y.push_back(int'(oY_Cont));
      cap_c.push_back(cyc);
    end
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_x.delete();
    cap_y.delete();
    cap_c.delete();
    drv_c.delete();
  endtask

  task automatic send_frame(input int lines, input int pix, input int base,
                            input int end_at, input int start_at);
    int k;
    k = 0;
    step(1'b1, 1'b0, 0);
    for (int ln = 0; ln < lines; ln++) begin
      for (int p = 0; p < pix; p++) begin
        iEND   = (k == end_at);
        iSTART = (k == start_at);
        step(1'b1, 1'b1, base + k);
        iEND   = 1'b0;
        iSTART = 1'b0;
        k++;
      end
      step(1'b1, 1'b0, 0);
    end
    repeat (3) step(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    #2;
    total++; if (oDVAL !== 1'b0) begin bad++; $display("FAIL reset_dval: got %0b want 0", oDVAL); end
    total++; if (oDATA !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", oDATA); end
    total++; if (oX_Cont !== '0 || oY_Cont !== '0) begin bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", oX_Cont, oY_Cont); end
    total++; if (oFrame_Cont !== '0) begin bad++; $display("FAIL reset_frames: got %0d want 0", oFrame_Cont); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", oBUSY); end
    #20;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    step(1'b0, 1'b0, 0);
    total++; if (oBUSY !== 1'b0 || oDVAL !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%0b dval=%0b want 0,0", oBUSY, oDVAL); end
  endtask

  task automatic test_basic();
    clear_caps();
    iSTART = 1'b1;
    step(1'b0, 1'b0, 0);
    iSTART = 1'b0;
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL arm_busy: got %0b want 1", oBUSY); end
    total++; if (oFrame_Cont !== 32'd0) begin bad++; $display("FAIL basic_frames_before: got %0d want 0", oFrame_Cont); end
    send_frame(2, 4, 1, -1, -1);
    total++; if (cap_d.size() !== 8) begin bad++; $display("FAIL basic_count: got %0d want 8", cap_d.size()); end
    for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
      total++;
      if (cap_d[i] !== i + 1 || cap_x[i] !== i % 4 || cap_y[i] !== i / 4) begin
        bad++;
        $display("FAIL basic_pix%0d: got d=%0d x=%0d y=%0d want d=%0d x=%0d y=%0d",
                 i, cap_d[i], cap_x[i], cap_y[i], i + 1, i % 4, i / 4);
      end
    end
    if (cap_c.size() > 0 && drv_c.size() > 0) begin
      total++; if (cap_c[0] - drv_c[0] !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", cap_c[0] - drv_c[0]); end
    end
    total++; if (oFrame_Cont !== 32'd1) begin bad++; $display("FAIL basic_frames_after: got %0d want 1", oFrame_Cont); end
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", oBUSY); end
    total++; if (oDATA !== 10'd8) begin bad++; $display("FAIL basic_hold: got %0d want 8", oDATA); end
  endtask

  task automatic test_row_limit();
    clear_caps();
    send_frame(3, 4, 1, -1, -1);
    total++; if (cap_d.size() !== 8) begin bad++; $display("FAIL rowlim_count: got %0d want 8", cap_d.size()); end
    if (cap_d.size() > 0) begin
      total++;
      if (cap_d[$] !== 8 || cap_x[$] !== 3 || cap_y[$] !== 1) begin
        bad++;
        $display("FAIL rowlim_last: got d=%0d x=%0d y=%0d want d=8 x=3 y=1", cap_d[$], cap_x[$], cap_y[$]);
      end
    end
    total++; if (oFrame_Cont !== 32'd2) begin bad++; $display("FAIL rowlim_frames: got %0d want 2", oFrame_Cont); end
    clear_caps();
    send_frame(1, 4, 20, -1, -1);
    total++; if (cap_d.size() !== 4) begin bad++; $display("FAIL rowlim_next_count: got %0d want 4", cap_d.size()); end
    if (cap_d.size() > 0) begin
      total++;
      if (cap_d[0] !== 20 || cap_x[0] !== 0 || cap_y[0] !== 0) begin
        bad++;
        $display("FAIL rowlim_next_first: got d=%0d x=%0d y=%0d want d=20 x=0 y=0", cap_d[0], cap_x[0], cap_y[0]);
      end
    end
    total++; if (oFrame_Cont !== 32'd3) begin bad++; $display("FAIL rowlim_next_frames: got %0d want 3", oFrame_Cont); end
  endtask

  task automatic test_end();
    clear_caps();
    send_frame(2, 4, 1, 5, -1);
    total++; if (cap_d.size() !== 8) begin bad++; $display("FAIL end_count: got %0d want 8", cap_d.size()); end
    if (cap_d.size() > 0) begin
      total++;
      if (cap_d[$] !== 8 || cap_x[$] !== 3 || cap_y[$] !== 1) begin
        bad++;
        $display("FAIL end_last: got d=%0d x=%0d y=%0d want d=8 x=3 y=1", cap_d[$], cap_x[$], cap_y[$]);
      end
    end
    total++; if (oFrame_Cont !== 32'd4) begin bad++; $display("FAIL end_frames: got %0d want 4", oFrame_Cont); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL end_busy: got %0b want 0", oBUSY); end
    clear_caps();
    send_frame(2, 4, 1, -1, -1);
    total++; if (cap_d.size() !== 0) begin bad++; $display("FAIL end_next_count: got %0d want 0", cap_d.size()); end
    total++; if (oFrame_Cont !== 32'd4) begin bad++; $display("FAIL end_next_frames: got %0d want 4", oFrame_Cont); end
  endtask

  task automatic test_start_end_same();
    clear_caps();
    iSTART = 1'b1;
    step(1'b0, 1'b0, 0);
    iSTART = 1'b0;
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL se_arm_busy: got %0b want 1", oBUSY); end
    iSTART = 1'b1;
    iEND   = 1'b1;
    step(1'b0, 1'b0, 0);
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL se_arm_to_idle: got %0b want 0", oBUSY); end
    step(1'b0, 1'b0, 0);
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL se_idle_stays: got %0b want 0", oBUSY); end
    iSTART = 1'b0;
    iEND   = 1'b0;
    send_frame(1, 4, 1, -1, -1);
    total++; if (cap_d.size() !== 0) begin bad++; $display("FAIL se_no_capture: got %0d want 0", cap_d.size()); end
  endtask

  task automatic test_midframe_start();
    clear_caps();
    send_frame(2, 4, 30, -1, 2);
    total++; if (cap_d.size() !== 0) begin bad++; $display("FAIL mid_partial_count: got %0d want 0", cap_d.size()); end
    total++; if (oBUSY !== 1'b1) begin bad++; $display("FAIL mid_armed: got %0b want 1", oBUSY); end
    total++; if (oFrame_Cont !== 32'd4) begin bad++; $display("FAIL mid_partial_frames: got %0d want 4", oFrame_Cont); end
    clear_caps();
    send_frame(1, 4, 40, -1, -1);
    total++; if (cap_d.size() !== 4) begin bad++; $display("FAIL mid_next_count: got %0d want 4", cap_d.size()); end
    for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
      total++;
      if (cap_d[i] !== 40 + i || cap_x[i] !== i || cap_y[i] !== 0) begin
        bad++;
        $display("FAIL mid_pix%0d: got d=%0d x=%0d y=%0d want d=%0d x=%0d y=0",
                 i, cap_d[i], cap_x[i], cap_y[i], 40 + i, i);
      end
    end
    total++; if (oFrame_Cont !== 32'd5) begin bad++; $display("FAIL mid_frames: got %0d want 5", oFrame_Cont); end
  endtask

  task automatic test_reset_midline();
    clear_caps();
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 50);
    step(1'b1, 1'b1, 51);
    total++; if (oDVAL !== 1'b1 || oDATA !== 10'd50) begin bad++; $display("FAIL rst_pre: dval=%0b data=%0d want 1,50", oDVAL, oDATA); end
    #2;
    iRST = 1'b0;
    #1;
    total++; if (oDVAL !== 1'b0 || oDATA !== '0) begin bad++; $display("FAIL rst_async_data: dval=%0b data=%0d want 0,0", oDVAL, oDATA); end
    total++; if (oX_Cont !== '0 || oY_Cont !== '0) begin bad++; $display("FAIL rst_async_xy: got %0d,%0d want 0,0", oX_Cont, oY_Cont); end
    total++; if (oFrame_Cont !== '0 || oBUSY !== 1'b0) begin bad++; $display("FAIL rst_async_ctrl: frames=%0d busy=%0b want 0,0", oFrame_Cont, oBUSY); end
    #2;
    iRST = 1'b1;
    clear_caps();
    step(1'b1, 1'b1, 52);
    step(1'b1, 1'b1, 53);
    step(1'b1, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 0);
    send_frame(1, 4, 60, -1, -1);
    total++; if (cap_d.size() !== 0) begin bad++; $display("FAIL rst_no_restart: got %0d want 0", cap_d.size()); end
    total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %0b want 0", oBUSY); end
    clear_caps();
    iSTART = 1'b1;
    step(1'b0, 1'b0, 0);
    iSTART = 1'b0;
    send_frame(1, 4, 70, -1, -1);
    total++; if (cap_d.size() !== 4) begin bad++; $display("FAIL rst_resume_count: got %0d want 4", cap_d.size()); end
    if (cap_d.size() > 0) begin
      total++;
      if (cap_d[0] !== 70 || cap_x[0] !== 0 || cap_y[0] !== 0) begin
        bad++;
        $display("FAIL rst_resume_first: got d=%0d x=%0d y=%0d want d=70 x=0 y=0", cap_d[0], cap_x[0], cap_y[0]);
      end
    end
    total++; if (oFrame_Cont !== 32'd1) begin bad++; $display("FAIL rst_resume_frames: got %0d want 1", oFrame_Cont); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    iRST   = 1'b0;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = '0;
    test_reset();
    test_basic();
    test_row_limit();
    test_end();
    test_start_end_same();
    test_midframe_start();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
